// File: rtl/mps_ext_do_sequencer.sv
// mps_ext_do_sequencer
// Drives the power-stage contactor/relay coils that the MPS operation FSM
// reads back on its external DI bus:
//   bit 1 main contactor, bit 2 slow-charge contactor, bit 3 discharge relay.
// The on/off sequence state codes are mapped to a coil target. Any change of
// target is applied with break-before-make between main and discharge, then
// checked against the DI readback. A readback that does not match in time
// latches a fault and forces the safe pattern (discharge engaged only).
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous reset, active-low
//   i_on_state    on-sequence state code
//   i_off_state   off-sequence state code
//   i_ext_di      DI readback, only bits [3:1] are used
//   i_fault_clr   single-cycle fault clear request
//   o_ext_do      coil drive, bits [15:4] and [0] tied low
//   o_busy        sequencer not idle
//   o_fault       latched readback fault
//   o_fault_code  lowest mismatching coil bit (1..3) captured at fault, else 0
module mps_ext_do_sequencer #(
  parameter int unsigned DEAD_CLKS  = 200_000,
  parameter int unsigned FB_TIMEOUT = 40_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_on_state,
  input  logic [3:0]  i_off_state,
  input  logic [15:0] i_ext_di,
  input  logic        i_fault_clr,
  output logic [15:0] o_ext_do,
  output logic        o_busy,
  output logic        o_fault,
  output logic [3:0]  o_fault_code
);

  // Coil vectors are ordered {discharge, slow, main} = DO bits {3,2,1}.
  localparam logic [2:0]  SAFE_DO   = 3'b100;
  localparam logic [31:0] DEAD_LAST = DEAD_CLKS - 1;
  localparam logic [31:0] FB_LAST   = FB_TIMEOUT - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BREAK,
    S_DEAD,
    S_MAKE,
    S_VERIFY,
    S_FAULT
  } state_e;

  state_e      state_q,      state_d;
  logic [2:0]  tgt_q,        tgt_d;
  logic [2:0]  lat_q,        lat_d;
  logic [2:0]  do_q,         do_d;
  logic [31:0] dead_cnt_q,   dead_cnt_d;
  logic [31:0] fb_cnt_q,     fb_cnt_d;
  logic        fault_q,      fault_d;
  logic [3:0]  fault_code_q, fault_code_d;

  logic [2:0]  di_fb;
  logic        unused_di;

  assign di_fb     = i_ext_di[3:1];
  assign unused_di = ^{i_ext_di[15:4], i_ext_di[0]};

  // Coil target from the sequence state codes; top rows take priority.
  function automatic logic [2:0] map_target(input logic [3:0] on_s,
                                            input logic [3:0] off_s,
                                            input logic [2:0] prev);
    logic [2:0] t;
    t = prev;
    if (on_s == 4'd15 || off_s == 4'd15)          t = SAFE_DO;
    else if (off_s == 4'd1)                       t = {prev[2:1], 1'b0};
    else if (off_s == 4'd2)                       t = SAFE_DO;
    else if (on_s == 4'd1 || on_s == 4'd4)        t = 3'b000;
    else if (on_s >= 4'd6 && on_s <= 4'd9)        t = 3'b010;
    else if (on_s == 4'd10 || on_s == 4'd11)      t = 3'b011;
    else if (on_s >= 4'd12 && on_s <= 4'd14)      t = 3'b001;
    return t;
  endfunction

  // Main and discharge must never overlap: a target that closes one while
  // the other is currently closed has to open the other first.
  function automatic logic needs_break(input logic [2:0] tgt,
                                       input logic [2:0] cur);
    return (tgt[0] && cur[2]) || (tgt[2] && cur[0]);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [2:0] m);
    if (m[0])      return 4'd1;
    else if (m[1]) return 4'd2;
    else if (m[2]) return 4'd3;
    else           return 4'd0;
  endfunction

  function automatic logic clr_allowed(input logic [3:0] s);
    return (s == 4'd0) || (s == 4'd15);
  endfunction

  always_comb begin
    state_d      = state_q;
    tgt_d        = map_target(i_on_state, i_off_state, tgt_q);
    lat_d        = lat_q;
    do_d         = do_q;
    dead_cnt_d   = dead_cnt_q;
    fb_cnt_d     = fb_cnt_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    case (state_q)
      S_IDLE: begin
        // Target changes seen here are frozen into lat for the whole sequence.
        if (tgt_q != do_q) begin
          lat_d = tgt_q;
          if (needs_break(tgt_q, do_q)) begin
            state_d = S_BREAK;
          end else begin
            state_d = S_MAKE;
            do_d    = tgt_q;
          end
        end
      end

      S_BREAK: begin
        // Only openings are applied; closings wait for the dead time.
        do_d       = do_q & lat_q;
        dead_cnt_d = '0;
        state_d    = S_DEAD;
      end

      S_DEAD: begin
        // The make value is loaded on the edge that ends the last dead cycle,
        // so the coils sit open for exactly DEAD_CLKS cycles.
        if (dead_cnt_q >= DEAD_LAST) begin
          state_d = S_MAKE;
          do_d    = lat_q;
        end else begin
          dead_cnt_d = sat_inc(dead_cnt_q);
        end
      end

      S_MAKE: begin
        do_d     = lat_q;
        fb_cnt_d = '0;
        state_d  = S_VERIFY;
      end

      S_VERIFY: begin
        // Match is tested before the timeout so a late match still wins.
        if (di_fb == do_q) begin
          state_d = S_IDLE;
        end else if (fb_cnt_q >= FB_LAST) begin
          state_d      = S_FAULT;
          do_d         = SAFE_DO;
          fault_d      = 1'b1;
          fault_code_d = lowest_bit(di_fb ^ do_q);
        end else begin
          fb_cnt_d = sat_inc(fb_cnt_q);
        end
      end

      S_FAULT: begin
        do_d = SAFE_DO;
        if (i_fault_clr && clr_allowed(i_on_state) && clr_allowed(i_off_state)) begin
          state_d      = S_IDLE;
          fault_d      = 1'b0;
          fault_code_d = 4'd0;
          tgt_d        = SAFE_DO;
        end
      end

      default: begin
        state_d = S_IDLE;
        do_d    = SAFE_DO;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      tgt_q        <= SAFE_DO;
      lat_q        <= SAFE_DO;
      do_q         <= SAFE_DO;
      dead_cnt_q   <= '0;
      fb_cnt_q     <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      lat_q        <= lat_d;
      do_q         <= do_d;
      dead_cnt_q   <= dead_cnt_d;
      fb_cnt_q     <= fb_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign o_ext_do     = {12'h000, do_q, 1'b0};
  assign o_busy       = (state_q != S_IDLE);
  assign o_fault      = fault_q;
  assign o_fault_code = fault_code_q;

endmodule
